// File: rtl/conv_mac_pipe_pkg.sv
// conv_pkg: shared sizing helpers, default-configuration constants and the
// output clamp used by the conv_mac_pipe convolution MAC stage.
package conv_pkg;

  localparam int unsigned DEF_DATA_WIDTH         = 8;
  localparam int unsigned DEF_WEIGHT_WIDTH       = 8;
  localparam int unsigned DEF_KERNEL_ROW_SIZE    = 3;
  localparam int unsigned DEF_KERNEL_COLUMN_SIZE = 3;

  // Width of the generic value handed to clamp_to_pixel.
  localparam int unsigned CLAMP_W = 64;

  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

  function automatic int unsigned calc_n(input int unsigned rows, input int unsigned cols);
    return rows * cols;
  endfunction

  function automatic int unsigned calc_add_stages(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned calc_prod_w(input int unsigned dw, input int unsigned ww);
    return dw + ww + 1;
  endfunction

  function automatic int unsigned calc_acc_w(input int unsigned dw, input int unsigned ww,
                                             input int unsigned n);
    return calc_prod_w(dw, ww) + calc_add_stages(n);
  endfunction

  localparam int unsigned N          = calc_n(DEF_KERNEL_ROW_SIZE, DEF_KERNEL_COLUMN_SIZE);
  localparam int unsigned ADD_STAGES = calc_add_stages(N);
  localparam int unsigned PROD_W     = calc_prod_w(DEF_DATA_WIDTH, DEF_WEIGHT_WIDTH);
  localparam int unsigned ACC_WIDTH  = PROD_W + ADD_STAGES;

  // Number of live operands after s pairwise reduction levels.
  function automatic int unsigned level_count(input int unsigned n, input int unsigned s);
    return (n + (1 << s) - 1) >> s;
  endfunction

  // Negative -> 0, above 2^dw-1 -> 2^dw-1, otherwise unchanged.
  function automatic logic [CLAMP_W-1:0] clamp_to_pixel(input logic signed [CLAMP_W-1:0] v,
                                                         input int unsigned dw);
    logic signed [CLAMP_W-1:0] maxv;
    maxv = (CLAMP_W'(1) << dw) - CLAMP_W'(1);
    if (v < 0)
      return '0;
    else if (v > maxv)
      return maxv;
    else
      return v;
  endfunction

endpackage

// File: rtl/conv_mac_pipe_adder_tree.sv
// conv_adder_tree: registered binary reduction of N signed operands, one level
// per clock, with a valid bit travelling alongside each level.
module conv_adder_tree #(
  parameter int unsigned N    = 9,
  parameter int unsigned IN_W = 17,
  localparam int unsigned STAGES = $clog2(N),
  localparam int unsigned OUT_W  = IN_W + STAGES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N*IN_W-1:0]       data_i,
  input  logic                    valid_i,
  output logic signed [OUT_W-1:0] sum_o,
  output logic                    valid_o
);
  import conv_pkg::level_count;

  logic signed [OUT_W-1:0] src_a [STAGES][N];
  logic signed [OUT_W-1:0] lvl_q [STAGES][N];
  logic [STAGES-1:0]       vld_q;

  // Operand set feeding each level: sign-extended inputs, then previous level.
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      src_a[0][k] = {{STAGES{data_i[k*IN_W+IN_W-1]}}, data_i[k*IN_W +: IN_W]};
    end
    for (int unsigned s = 1; s < STAGES; s++) begin
      for (int unsigned k = 0; k < N; k++) begin
        src_a[s][k] = lvl_q[s-1][k];
      end
    end
  end

  // Pairwise adds per level; an odd leftover operand is simply re-registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        for (int unsigned k = 0; k < N; k++) begin
          lvl_q[s][k] <= '0;
        end
      end
    end else begin
      vld_q[0] <= valid_i;
      for (int unsigned s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
      for (int unsigned s = 0; s < STAGES; s++) begin
        for (int unsigned k = 0; k < N; k++) begin
          if (k < level_count(N, s + 1)) begin
            if (2 * k + 1 < level_count(N, s))
              lvl_q[s][k] <= src_a[s][2*k] + src_a[s][2*k+1];
            else
              lvl_q[s][k] <= src_a[s][2*k];
          end else begin
            lvl_q[s][k] <= '0;
          end
        end
      end
    end
  end

  assign sum_o   = lvl_q[STAGES-1][0];
  assign valid_o = vld_q[STAGES-1];

endmodule

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: serially loaded signed kernel, element-wise multiply with an
// unsigned pixel window, pipelined adder tree, shift and clamp to one pixel.
// Fixed latency, full throughput, no backpressure.
// Define CONV_MAC_ROUND_EN for round-half-up on the output shift; otherwise
// the shift truncates toward minus infinity.
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned WEIGHT_WIDTH       = 8,
  parameter int unsigned KERNEL_ROW_SIZE    = 3,
  parameter int unsigned KERNEL_COLUMN_SIZE = 3,
  parameter int unsigned OUT_SHIFT          = 0
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [DATA_WIDTH*KERNEL_ROW_SIZE*KERNEL_COLUMN_SIZE-1:0] in_matrix,
  input  logic                                                 valid_in,
  input  logic [WEIGHT_WIDTH-1:0]                              weight_in,
  input  logic                                                 weight_valid,
  output logic                                                 weights_loaded,
  output logic [DATA_WIDTH-1:0]                                out_pixel,
  output logic                                                 valid_out
);

  localparam int unsigned NTAP       = calc_n(KERNEL_ROW_SIZE, KERNEL_COLUMN_SIZE);
  localparam int unsigned ADD_ST     = calc_add_stages(NTAP);
  localparam int unsigned PROD_WIDTH = calc_prod_w(DATA_WIDTH, WEIGHT_WIDTH);
  localparam int unsigned ACC_W      = calc_acc_w(DATA_WIDTH, WEIGHT_WIDTH, NTAP);
  localparam int unsigned SH_W       = ACC_W + 1;
  localparam int unsigned CNT_W      = $clog2(NTAP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NTAP - 1);

  logic [WEIGHT_WIDTH-1:0]        weight_q [NTAP];
  logic [CNT_W-1:0]               cnt_q;
  logic                           loaded_q;
  logic                           accept;
  logic signed [PROD_WIDTH-1:0]   prod_d [NTAP];
  logic signed [PROD_WIDTH-1:0]   prod_q [NTAP];
  logic                           mvalid_q;
  logic [NTAP*PROD_WIDTH-1:0]     prod_flat;
  logic signed [ACC_W-1:0]        tree_sum;
  logic                           tree_valid;
  logic signed [SH_W-1:0]         acc_r;
  logic signed [SH_W-1:0]         sh_d;
  logic [CLAMP_W-1:0]             clamp_res;
  logic [DATA_WIDTH-1:0]          pix_d;
  logic [DATA_WIDTH-1:0]          out_q;
  logic                           vout_q;

  assign accept         = valid_in & loaded_q;
  assign weights_loaded = loaded_q;

  // Serial kernel load; a weight arriving on a loaded kernel restarts at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NTAP; k++) weight_q[k] <= '0;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
    end else if (weight_valid) begin
      if (loaded_q) begin
        loaded_q    <= 1'b0;
        weight_q[0] <= weight_in;
        cnt_q       <= CNT_W'(1);
      end else begin
        weight_q[cnt_q] <= weight_in;
        if (cnt_q == CNT_LAST) begin
          loaded_q <= 1'b1;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Products of zero-extended pixels and sign-extended pre-edge weights.
  always_comb begin
    for (int unsigned k = 0; k < NTAP; k++) begin
      prod_d[k] = $signed({{(PROD_WIDTH-DATA_WIDTH){1'b0}}, in_matrix[DATA_WIDTH*k +: DATA_WIDTH]})
                * $signed({{(PROD_WIDTH-WEIGHT_WIDTH){weight_q[k][WEIGHT_WIDTH-1]}}, weight_q[k]});
    end
  end

  // Stage M: register products and the accept strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NTAP; k++) prod_q[k] <= '0;
      mvalid_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NTAP; k++) prod_q[k] <= prod_d[k];
      mvalid_q <= accept;
    end
  end

  // Flatten products for the tree.
  always_comb begin
    prod_flat = '0;
    for (int unsigned k = 0; k < NTAP; k++) prod_flat[k*PROD_WIDTH +: PROD_WIDTH] = prod_q[k];
  end

  conv_adder_tree #(
    .N    (NTAP),
    .IN_W (PROD_WIDTH)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (prod_flat),
    .valid_i (mvalid_q),
    .sum_o   (tree_sum),
    .valid_o (tree_valid)
  );

`ifdef CONV_MAC_ROUND_EN
  localparam logic [SH_W-1:0] RND =
    (OUT_SHIFT == 0) ? '0 : (SH_W'(1) << ((OUT_SHIFT == 0) ? 0 : OUT_SHIFT - 1));
`else
  localparam logic [SH_W-1:0] RND = '0;
`endif

  // Stage Q datapath: optional rounding bias, arithmetic shift, clamp.
  always_comb begin
    acc_r     = $signed({tree_sum[ACC_W-1], tree_sum} + RND);
    sh_d      = acc_r >>> OUT_SHIFT;
    clamp_res = clamp_to_pixel({{(CLAMP_W-SH_W){sh_d[SH_W-1]}}, sh_d}, DATA_WIDTH);
    pix_d     = DATA_WIDTH'(clamp_res);
  end

  // Stage Q register: pixel updates only with a valid result, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      vout_q <= 1'b0;
    end else begin
      vout_q <= tree_valid;
      if (tree_valid) out_q <= pix_d;
    end
  end

  assign out_pixel = out_q;
  assign valid_out = vout_q;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Scoreboard bench for conv_mac_pipe: one instance with OUT_SHIFT=0 and one
// with OUT_SHIFT=3 share all inputs; expected pixels and output cycles are
// queued at issue time and popped by a monitor on valid_out.
module tb_conv_mac_pipe;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [71:0] in_matrix;
  logic        valid_in;
  logic [7:0]  weight_in;
  logic        weight_valid;
  logic        wl0, wl3, vo0, vo3;
  pixel_t      px0, px3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] px;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];

  conv_mac_pipe #(
    .DATA_WIDTH(8), .WEIGHT_WIDTH(8), .KERNEL_ROW_SIZE(3), .KERNEL_COLUMN_SIZE(3), .OUT_SHIFT(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_matrix(in_matrix), .valid_in(valid_in),
    .weight_in(weight_in), .weight_valid(weight_valid),
    .weights_loaded(wl0), .out_pixel(px0), .valid_out(vo0)
  );

  conv_mac_pipe #(
    .DATA_WIDTH(8), .WEIGHT_WIDTH(8), .KERNEL_ROW_SIZE(3), .KERNEL_COLUMN_SIZE(3), .OUT_SHIFT(3)
  ) u_dut_sh (
    .clk(clk), .rst_n(rst_n), .in_matrix(in_matrix), .valid_in(valid_in),
    .weight_in(weight_in), .weight_valid(weight_valid),
    .weights_loaded(wl3), .out_pixel(px3), .valid_out(vo3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [71:0] seq_win(input int base, input int step);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'(base + step * k);
    return w;
  endfunction

  function automatic logic [71:0] kern(input int ctr, input int oth);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[8*k +: 8] = (k == 4) ? 8'(ctr) : 8'(oth);
    return w;
  endfunction

  // Expected pixel of the OUT_SHIFT=3 instance for a given signed sum.
  function automatic logic [7:0] shift_px(input int s);
    int r;
`ifdef CONV_MAC_ROUND_EN
    r = (s + 4) >>> 3;
`else
    r = s >>> 3;
`endif
    if (r < 0) return 8'd0;
    if (r > 255) return 8'd255;
    return 8'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Valid result appears on the 6th rising edge counting the accepting edge.
  task automatic push(input logic [7:0] e0, input logic [7:0] e3);
    exp_t e;
    e.cyc = cyc + 6;
    e.px  = e0;
    q0.push_back(e);
    e.px  = e3;
    q3.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input logic [71:0] k, input bit with_win);
    for (int i = 0; i < 9; i++) begin
      weight_in    = k[8*i +: 8];
      weight_valid = 1'b1;
      if (with_win) begin
        in_matrix = seq_win(i + 1, 1);
        valid_in  = 1'b1;
      end
      tick();
    end
    weight_valid = 1'b0;
    valid_in     = 1'b0;
  endtask

  // Monitor: every valid_out must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (vo0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid_sh0: pixel %0d with nothing queued (cycle %0d)", px0, cyc);
      end else begin
        e = q0.pop_front();
        if (px0 !== e.px) begin
          errors++;
          $display("FAIL pixel_sh0: got %0d expected %0d (cycle %0d)", px0, e.px, cyc);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL latency_sh0: valid at cycle %0d expected cycle %0d", cyc, e.cyc);
        end
      end
    end
    if (vo3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid_sh3: pixel %0d with nothing queued (cycle %0d)", px3, cyc);
      end else begin
        e = q3.pop_front();
        if (px3 !== e.px) begin
          errors++;
          $display("FAIL pixel_sh3: got %0d expected %0d (cycle %0d)", px3, e.px, cyc);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL latency_sh3: valid at cycle %0d expected cycle %0d", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    logic [71:0] kb;
    logic [71:0] w;

    rst_n        = 1'b0;
    in_matrix    = '0;
    valid_in     = 1'b0;
    weight_in    = '0;
    weight_valid = 1'b0;
    repeat (3) tick();
    chk("reset_weights_loaded", int'(wl0), 0);
    chk("reset_out_pixel", int'(px0), 0);
    chk("reset_valid_out", int'(vo0), 0);
    chk("reset_weights_loaded_sh3", int'(wl3), 0);
    rst_n = 1'b1;
    tick();

    // Windows offered during the first load (including the 9th weight) drop.
    load(kern(1, 1), 1'b1);
    chk("loaded_after_9", int'(wl0), 1);

    // Sum of 1..9 with unit weights.
    in_matrix = seq_win(1, 1);
    valid_in  = 1'b1;
    push(8'd45, shift_px(45));
    tick();
    valid_in = 1'b0;
    repeat (8) tick();

    // Center-tap kernel, 20 back-to-back windows.
    load(kern(1, 0), 1'b0);
    chk("loaded_center", int'(wl0), 1);
    for (int t = 0; t < 20; t++) begin
      w = {$urandom(), $urandom(), $urandom()};
      in_matrix = w;
      valid_in  = 1'b1;
      push(w[39:32], shift_px(int'(w[39:32])));
      tick();
    end
    valid_in = 1'b0;
    repeat (8) tick();

    // Negative kernel clamps to 0; full-scale kernel saturates to 255.
    load(kern(-1, -1), 1'b0);
    in_matrix = seq_win(5, 0);
    valid_in  = 1'b1;
    push(8'd0, 8'd0);
    tick();
    valid_in = 1'b0;
    load(kern(127, 127), 1'b0);
    in_matrix = seq_win(255, 0);
    valid_in  = 1'b1;
    push(8'd255, 8'd255);
    tick();
    valid_in = 1'b0;
    repeat (8) tick();

    // Reload starting with an accepted window: old kernel used, next window dropped.
    load(kern(1, 1), 1'b0);
    kb           = kern(1, 0);
    in_matrix    = seq_win(1, 1);
    valid_in     = 1'b1;
    weight_in    = kb[7:0];
    weight_valid = 1'b1;
    push(8'd45, shift_px(45));
    tick();
    chk("reload_drops_loaded", int'(wl0), 0);
    in_matrix = seq_win(50, 1);
    weight_in = kb[15:8];
    tick();
    valid_in = 1'b0;
    for (int i = 2; i < 9; i++) begin
      weight_in = kb[8*i +: 8];
      tick();
    end
    weight_valid = 1'b0;
    chk("reload_complete", int'(wl0), 1);
    in_matrix = seq_win(10, 3);
    valid_in  = 1'b1;
    push(8'd22, shift_px(22));
    tick();
    valid_in = 1'b0;
    repeat (8) tick();

    // Reset three cycles after an accepted window discards it and the kernel.
    in_matrix = seq_win(1, 1);
    valid_in  = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    q0.delete();
    q3.delete();
    tick();
    tick();
    chk("midreset_weights_loaded", int'(wl0), 0);
    chk("midreset_out_pixel", int'(px0), 0);
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      in_matrix = seq_win(t + 3, 1);
      valid_in  = 1'b1;
      tick();
      chk("postreset_weights_loaded", int'(wl0), 0);
      chk("postreset_out_pixel", int'(px0), 0);
    end
    valid_in = 1'b0;

    // Partial load interrupted by reset leaves the kernel lost.
    kb = kern(1, 1);
    for (int i = 0; i < 4; i++) begin
      weight_in    = kb[8*i +: 8];
      weight_valid = 1'b1;
      tick();
    end
    weight_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("partial_reset_loaded", int'(wl0), 0);
    for (int i = 0; i < 8; i++) begin
      weight_in    = kb[8*i +: 8];
      weight_valid = 1'b1;
      tick();
    end
    chk("eight_of_nine_loaded", int'(wl0), 0);
    weight_in = kb[71:64];
    tick();
    weight_valid = 1'b0;
    chk("full_reload_loaded", int'(wl0), 1);
    in_matrix = seq_win(2, 2);
    valid_in  = 1'b1;
    push(8'd90, shift_px(90));
    tick();
    valid_in = 1'b0;

    repeat (12) tick();
    chk("queue_drained", q0.size() + q3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
